regfile: RTL and testbench

- Architectural integer register file, directly downstream of the retire stage.
- Consumes the retire write port (wren/wraddr/wrdata at RB0) and serves two synchronous read ports to the decode/register-read stage.
- Holds a per-register pending scoreboard: set when the decode stage dispatches a register-writing uop, cleared when retire writes that register.
- Produces a hazard/stall indication for the two sources being read.

---
 rtl/instr_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 87 ++++++++
 rtl/regfile.sv | 110 +++++++++++
 tb/tb_regfile.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// ---------------------------------------------------------------------------
// instr: shared instruction/architectural-state definitions.
//   t_rv_reg_addr  - architectural register index
//   t_rv_reg_data  - architectural register value
//   NUM_RV_REGS    - number of architectural integer registers (x0..x31)
// ---------------------------------------------------------------------------
package instr;

    localparam int NUM_RV_REGS = 32;

    typedef logic [$clog2(NUM_RV_REGS)-1:0] t_rv_reg_addr;
    typedef logic [31:0]                    t_rv_reg_data;

endpackage : instr

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard: per-register pending bits and source hazard detection.
//
// A pending bit is set when decode dispatches a uop that writes the register
// and cleared by the retire write to it.  If set and clear hit the same
// register in one cycle, set wins, because the dispatching uop is the younger
// producer.
//
// Optional build macro REGFILE_BYPASS_EN:
//   defined   - the retiring register is masked out of the hazard in the
//               write cycle, so a dependent read can issue alongside retire
//               (the register file forwards the data).
//   undefined - the clear only becomes visible through the pending register
//               after the write edge, so the hazard holds through the write
//               cycle.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   sb_set, sb_addr       dispatch of a register-writing uop
//   wren, wraddr          retire write
//   rden, rdaddr0/1       decode read request and its two sources
//   hazard                a valid source of the current request is pending
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sb_set,
    input  logic [AW-1:0] sb_addr,
    input  logic          wren,
    input  logic [AW-1:0] wraddr,
    input  logic          rden,
    input  logic [AW-1:0] rdaddr0,
    input  logic [AW-1:0] rdaddr1,
    output logic          hazard
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_REGS-1:0] pending_eff;
    logic                src0_busy;
    logic                src1_busy;

    // Clear first, then set, so a same-cycle set overrides the clear.
    always_comb begin
        pending_nxt = pending;
        if (wren && (wraddr != '0)) begin
            pending_nxt[wraddr] = 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
            pending_nxt[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        pending_eff = pending;
`ifdef REGFILE_BYPASS_EN
        if (wren && (wraddr != '0)) begin
            pending_eff[wraddr] = 1'b0;
        end
`endif
    end

    assign src0_busy = pending_eff[rdaddr0] && (rdaddr0 != '0);
    assign src1_busy = pending_eff[rdaddr1] && (rdaddr1 != '0);
    assign hazard    = rden && (src0_busy || src1_busy);

`ifdef ASSERT
    // Retire is in order, so every retiring non-zero destination must have
    // been marked by its dispatch.
    a_retire_pending : assert property (
        @(posedge clk) disable iff (reset)
        (wren && (wraddr != '0)) |-> pending[wraddr]
    );
`endif

endmodule : regfile_scoreboard

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile: architectural integer register file between retire and decode.
//
// One retire write port (RB0), two registered read ports (request at RD0,
// data at RD1, latency 1), and a pending scoreboard that flags read hazards.
// x0 is hardwired to zero: writes are dropped and reads return 0.
// When no read is requested the read data holds and rdvalid_rd1 drops.
// Hazard is informational only; the read is still performed.
//
// Optional build macro REGFILE_BYPASS_EN:
//   defined   - a same-cycle read of the retiring address returns wrdata_rb0.
//   undefined - a same-cycle read returns the old register value.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   wren_rb0/wraddr_rb0/wrdata_rb0  retire write
//   rden_rd0, rdaddr0_rd0/1_rd0     read request (both ports)
//   sb_set_rd0, sb_addr_rd0         dispatch marks a destination pending
//   hazard_rd0                      a valid source of the request is pending
//   rddata0_rd1, rddata1_rd1        source data, one cycle after request
//   rdvalid_rd1                     read data valid
// ---------------------------------------------------------------------------
module regfile
    import instr::*;
#(
    parameter int NUM_REGS = NUM_RV_REGS,
    parameter int XLEN     = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wren_rb0,
    input  logic [AW-1:0]   wraddr_rb0,
    input  logic [XLEN-1:0] wrdata_rb0,
    input  logic            rden_rd0,
    input  logic [AW-1:0]   rdaddr0_rd0,
    input  logic [AW-1:0]   rdaddr1_rd0,
    input  logic            sb_set_rd0,
    input  logic [AW-1:0]   sb_addr_rd0,
    output logic            hazard_rd0,
    output logic [XLEN-1:0] rddata0_rd1,
    output logic [XLEN-1:0] rddata1_rd1,
    output logic            rdvalid_rd1
);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic [XLEN-1:0] src0_rd0;
    logic [XLEN-1:0] src1_rd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wren_rb0 && (wraddr_rb0 != '0)) begin
            regs[wraddr_rb0] <= wrdata_rb0;
        end
    end

    // Zero check comes last so x0 never picks up forwarded data.
    always_comb begin
        src0_rd0 = regs[rdaddr0_rd0];
        src1_rd0 = regs[rdaddr1_rd0];
`ifdef REGFILE_BYPASS_EN
        if (wren_rb0 && (wraddr_rb0 == rdaddr0_rd0)) begin
            src0_rd0 = wrdata_rb0;
        end
        if (wren_rb0 && (wraddr_rb0 == rdaddr1_rd0)) begin
            src1_rd0 = wrdata_rb0;
        end
`endif
        if (rdaddr0_rd0 == '0) begin
            src0_rd0 = '0;
        end
        if (rdaddr1_rd0 == '0) begin
            src1_rd0 = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rddata0_rd1 <= '0;
            rddata1_rd1 <= '0;
            rdvalid_rd1 <= 1'b0;
        end else begin
            rdvalid_rd1 <= rden_rd0;
            if (rden_rd0) begin
                rddata0_rd1 <= src0_rd0;
                rddata1_rd1 <= src1_rd0;
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .sb_set  (sb_set_rd0),
        .sb_addr (sb_addr_rd0),
        .wren    (wren_rb0),
        .wraddr  (wraddr_rb0),
        .rden    (rden_rd0),
        .rdaddr0 (rdaddr0_rd0),
        .rdaddr1 (rdaddr1_rd0),
        .hazard  (hazard_rd0)
    );

endmodule : regfile

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile: directed bench for regfile.  Inputs change 1 ns after a rising
// edge; registered outputs are sampled there and combinational hazard is
// sampled 1 ns after the inputs change.  Expected values that depend on
// REGFILE_BYPASS_EN follow the same macro.
// ---------------------------------------------------------------------------
module tb_regfile;

    localparam int AW   = 5;
    localparam int XLEN = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            wren_rb0;
    logic [AW-1:0]   wraddr_rb0;
    logic [XLEN-1:0] wrdata_rb0;
    logic            rden_rd0;
    logic [AW-1:0]   rdaddr0_rd0;
    logic [AW-1:0]   rdaddr1_rd0;
    logic            sb_set_rd0;
    logic [AW-1:0]   sb_addr_rd0;
    logic            hazard_rd0;
    logic [XLEN-1:0] rddata0_rd1;
    logic [XLEN-1:0] rddata1_rd1;
    logic            rdvalid_rd1;

    int n_total  = 0;
    int n_passed = 0;

    regfile dut (
        .clk         (clk),
        .reset       (reset),
        .wren_rb0    (wren_rb0),
        .wraddr_rb0  (wraddr_rb0),
        .wrdata_rb0  (wrdata_rb0),
        .rden_rd0    (rden_rd0),
        .rdaddr0_rd0 (rdaddr0_rd0),
        .rdaddr1_rd0 (rdaddr1_rd0),
        .sb_set_rd0  (sb_set_rd0),
        .sb_addr_rd0 (sb_addr_rd0),
        .hazard_rd0  (hazard_rd0),
        .rddata0_rd1 (rddata0_rd1),
        .rddata1_rd1 (rddata1_rd1),
        .rdvalid_rd1 (rdvalid_rd1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        wren_rb0    = 1'b0;
        wraddr_rb0  = '0;
        wrdata_rb0  = '0;
        rden_rd0    = 1'b0;
        rdaddr0_rd0 = '0;
        rdaddr1_rd0 = '0;
        sb_set_rd0  = 1'b0;
        sb_addr_rd0 = '0;
    endtask

    task automatic dispatch(input logic [AW-1:0] a);
        sb_set_rd0  = 1'b1;
        sb_addr_rd0 = a;
        tick();
        sb_set_rd0  = 1'b0;
    endtask

    task automatic retire(input logic [AW-1:0] a, input logic [31:0] d);
        wren_rb0   = 1'b1;
        wraddr_rb0 = a;
        wrdata_rb0 = d;
        tick();
        wren_rb0   = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_rdvalid", 32'(rdvalid_rd1), 32'h0);
        chk("reset_rddata0", rddata0_rd1, 32'h0);
        chk("reset_rddata1", rddata1_rd1, 32'h0);
        chk("reset_hazard", 32'(hazard_rd0), 32'h0);
        reset = 1'b0;
        tick();

        // Reset mid-stream
        dispatch(5'd5);
        retire(5'd5, 32'hDEADBEEF);
        rden_rd0 = 1'b1; rdaddr0_rd0 = 5'd5;
        tick();
        chk("pre_reset_x5", rddata0_rd1, 32'hDEADBEEF);
        rden_rd0 = 1'b0;
        dispatch(5'd6);
        rden_rd0 = 1'b1; rdaddr1_rd0 = 5'd6;
        settle();
        chk("pre_reset_hazard_x6", 32'(hazard_rd0), 32'h1);
        reset = 1'b1;
        settle();
        chk("mid_reset_rdvalid", 32'(rdvalid_rd1), 32'h0);
        chk("mid_reset_rddata0", rddata0_rd1, 32'h0);
        chk("mid_reset_hazard", 32'(hazard_rd0), 32'h0);
        tick();
        chk("mid_reset_rdvalid_clk", 32'(rdvalid_rd1), 32'h0);
        reset = 1'b0;
        rdaddr1_rd0 = 5'd0;
        tick();
        chk("post_reset_x5", rddata0_rd1, 32'h0);
        chk("post_reset_rdvalid", 32'(rdvalid_rd1), 32'h1);
        idle();

        // x0 handling
        retire(5'd0, 32'h12345678);
        rden_rd0 = 1'b1;
        tick();
        chk("x0_read_p0", rddata0_rd1, 32'h0);
        chk("x0_read_p1", rddata1_rd1, 32'h0);
        rden_rd0 = 1'b0;
        dispatch(5'd0);
        rden_rd0 = 1'b1;
        settle();
        chk("x0_hazard", 32'(hazard_rd0), 32'h0);
        tick();
        idle();

        // Basic read/write
        dispatch(5'd3);
        retire(5'd3, 32'hA5A5A5A5);
        rden_rd0 = 1'b1; rdaddr0_rd0 = 5'd3; rdaddr1_rd0 = 5'd0;
        settle();
        chk("x3_hazard_after_retire", 32'(hazard_rd0), 32'h0);
        tick();
        chk("x3_rddata0", rddata0_rd1, 32'hA5A5A5A5);
        chk("x3_rddata1", rddata1_rd1, 32'h0);
        chk("x3_rdvalid", 32'(rdvalid_rd1), 32'h1);
        rden_rd0 = 1'b0;
        tick();
        chk("idle_rdvalid", 32'(rdvalid_rd1), 32'h0);
        chk("idle_rddata0_hold", rddata0_rd1, 32'hA5A5A5A5);
        idle();

        // hazard gated by rden
        dispatch(5'd10);
        rdaddr0_rd0 = 5'd10;
        settle();
        chk("x10_hazard_no_rden", 32'(hazard_rd0), 32'h0);
        rden_rd0 = 1'b1;
        settle();
        chk("x10_hazard_rden", 32'(hazard_rd0), 32'h1);
        rden_rd0 = 1'b0;
        retire(5'd10, 32'h10);
        idle();

        // Scoreboard x7
        dispatch(5'd7);
        rden_rd0 = 1'b1; rdaddr0_rd0 = 5'd7;
        settle();
        chk("x7_hazard_pending", 32'(hazard_rd0), 32'h1);
        tick();
        wren_rb0 = 1'b1; wraddr_rb0 = 5'd7; wrdata_rb0 = 32'h11;
        settle();
        chk("x7_hazard_write_cycle", 32'(hazard_rd0), BYP ? 32'h0 : 32'h1);
        tick();
        chk("x7_same_cycle_read", rddata0_rd1, BYP ? 32'h11 : 32'h0);
        wren_rb0 = 1'b0;
        settle();
        chk("x7_hazard_after", 32'(hazard_rd0), 32'h0);
        tick();
        chk("x7_rddata0", rddata0_rd1, 32'h11);
        idle();

        // Same-cycle set and clear to x9
        dispatch(5'd9);
        sb_set_rd0 = 1'b1; sb_addr_rd0 = 5'd9;
        retire(5'd9, 32'h99);
        sb_set_rd0 = 1'b0;
        rden_rd0 = 1'b1; rdaddr0_rd0 = 5'd9;
        settle();
        chk("x9_set_wins_hazard", 32'(hazard_rd0), 32'h1);
        tick();
        wren_rb0 = 1'b1; wraddr_rb0 = 5'd9; wrdata_rb0 = 32'h9A;
        settle();
        chk("x9_hazard_write_cycle", 32'(hazard_rd0), BYP ? 32'h0 : 32'h1);
        tick();
        wren_rb0 = 1'b0;
        settle();
        chk("x9_hazard_cleared", 32'(hazard_rd0), 32'h0);
        tick();
        chk("x9_rddata0", rddata0_rd1, 32'h9A);
        idle();

        // Both sources: x2 pending, x4 not
        dispatch(5'd4);
        retire(5'd4, 32'h44444444);
        dispatch(5'd2);
        rden_rd0 = 1'b1; rdaddr0_rd0 = 5'd2; rdaddr1_rd0 = 5'd4;
        settle();
        chk("both_hazard_x2", 32'(hazard_rd0), 32'h1);
        wren_rb0 = 1'b1; wraddr_rb0 = 5'd2; wrdata_rb0 = 32'h22222222;
        settle();
        chk("both_hazard_write_cycle", 32'(hazard_rd0), BYP ? 32'h0 : 32'h1);
        tick();
        chk("both_same_cycle_x4", rddata1_rd1, 32'h44444444);
        wren_rb0 = 1'b0;
        settle();
        chk("both_hazard_cleared", 32'(hazard_rd0), 32'h0);
        tick();
        chk("both_rddata0", rddata0_rd1, 32'h22222222);
        chk("both_rddata1", rddata1_rd1, 32'h44444444);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule : tb_regfile
